// File: rtl/msg_fetch.sv
// msg_fetch: message byte prefetcher for the decrypt sequencer.
// Reads message bytes from a memory with one cycle of read latency and
// buffers them in a small FIFO. Reads are credit-limited, so the FIFO is
// never written while full. The block also produces the preamble and message
// completion levels from the number of bytes popped.
module msg_fetch #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PRE_LEN = 8,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] msg_len,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] fIn,
  output logic          fInValid,
  input  logic          getNext,
  output logic          preambleDone,
  output logic          messageDone,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] len;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] pop_cnt;
  logic          in_flight;
  logic [CW-1:0] occ;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] fifo [DEPTH];
  logic          pre_done, msg_done;

  logic          accept, issue, push, pop, last_read, last_pop, pre_hit;
  logic [CW:0]   credit;

  // Datapath decode: read credit, push/pop qualifiers and end-of-message detection.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the value just computed.
    accept    = start && ((state == IDLE) || (state == DONE));
    credit    = {1'b0, occ} + (CW+1)'(in_flight);
    issue     = (state == FETCH) && (rd_addr < len) && (credit < (CW+1)'(DEPTH));
    push      = in_flight;
    pop       = getNext && (occ != '0);
    last_read = issue && (rd_addr == len - AW'(1));
    last_pop  = pop && (pop_cnt == len - AW'(1));
    // A message shorter than the preamble completes its preamble on the last pop.
    pre_hit   = (int'(pop_cnt) + 1 >= PRE_LEN) || last_pop;
  end

  // Next-state logic for the fetch sequence.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (msg_len == '0) ? DONE : FETCH;
      FETCH:      if (last_read) state_nxt = DRAIN;
      DRAIN:      if (last_pop) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Counters, FIFO pointers/occupancy and the completion levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len       <= '0;
      rd_addr   <= '0;
      pop_cnt   <= '0;
      in_flight <= 1'b0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_done  <= 1'b0;
      msg_done  <= 1'b0;
    end else if (accept) begin
      len       <= msg_len;
      rd_addr   <= '0;
      pop_cnt   <= '0;
      in_flight <= 1'b0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      // An empty message is complete the moment it is accepted.
      pre_done  <= (msg_len == '0);
      msg_done  <= (msg_len == '0);
    end else begin
      in_flight <= issue;
      if (issue) rd_addr <= rd_addr + AW'(1);
      if (push)  wr_ptr  <= wr_ptr + PW'(1);
      if (pop)   rd_ptr  <= rd_ptr + PW'(1);
      occ <= occ + CW'(push) - CW'(pop);
      if (pop) begin
        pop_cnt <= pop_cnt + AW'(1);
        if (pre_hit)  pre_done <= 1'b1;
        if (last_pop) msg_done <= 1'b1;
      end
    end
  end

  // FIFO storage: capture the returning read data at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    if (push) fifo[wr_ptr] <= mem_data;
  end

  assign mem_rd       = issue;
  assign mem_addr     = issue ? rd_addr : '0;
  assign fInValid     = (occ != '0);
  assign fIn          = fInValid ? fifo[rd_ptr] : '0;
  assign busy         = (state == FETCH) || (state == DRAIN);
  assign preambleDone = pre_done;
  assign messageDone  = msg_done;

endmodule

// File: tb/tb_msg_fetch.sv
// Directed testbench for msg_fetch with a synchronous-read memory model
// where mem[i] = i. Inputs change 1ns after the rising edge; outputs are
// checked on the falling edge.
module tb_msg_fetch;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] msg_len = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] fIn;
  logic          fInValid;
  logic          getNext = 1'b0;
  logic          preambleDone;
  logic          messageDone;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [256];
  int rd_log[$];
  int pop_log[$];

  msg_fetch #(.DW(DW), .AW(AW), .PRE_LEN(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .fIn(fIn), .fInValid(fInValid), .getNext(getNext),
    .preambleDone(preambleDone), .messageDone(messageDone), .busy(busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = DW'(i);

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd) rd_log.push_back(int'(mem_addr));
      if (fInValid && getNext) pop_log.push_back(int'(fIn));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag, input int bound);
    int n = 0;
    while (!messageDone && n < bound) begin
      next();
      settle();
      n++;
    end
    check(tag, messageDone, 1);
  endtask

  task automatic check_log_seq(input string tag, input int which, input int count);
    int sz;
    sz = (which == 0) ? rd_log.size() : pop_log.size();
    check({tag, "_size"}, sz, count);
    for (int i = 0; i < count; i++) begin
      int v;
      if (i < sz) v = (which == 0) ? rd_log[i] : pop_log[i];
      else        v = -1;
      check(tag, v, i);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {mem_rd, mem_addr, fIn, fInValid, preambleDone, messageDone, busy};
  endfunction

  initial begin
    // Reset state
    #3;
    check("reset_outputs", out_vec(), 0);
    repeat (2) next();
    rst = 1'b1;
    settle();
    check("idle_outputs", out_vec(), 0);

    // Zero-length message from IDLE
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 0;
    settle();
    check("len0_msg_before", messageDone, 0);
    check("len0_pre_before", preambleDone, 0);
    next(); start = 1'b0;
    settle();
    check("len0_msg", messageDone, 1);
    check("len0_pre", preambleDone, 1);
    check("len0_busy", busy, 0);
    repeat (3) begin next(); settle(); end
    check("len0_no_reads", rd_log.size(), 0);

    // len=10, getNext held high: streaming with 2-cycle latency
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 10; getNext = 1'b1;
    settle();
    check("t1_busy_before", busy, 0);
    next(); start = 1'b0;
    settle();
    check("t1_rd0", mem_rd, 1);
    check("t1_addr0", mem_addr, 0);
    check("t1_msg_cleared", messageDone, 0);
    check("t1_pre_cleared", preambleDone, 0);
    next(); settle();
    check("t1_rd1", mem_rd, 1);
    check("t1_addr1", mem_addr, 1);
    check("t1_empty_c2", fInValid, 0);
    for (int k = 0; k < 10; k++) begin
      next(); settle();
      check("t1_valid", fInValid, 1);
      check("t1_byte", fIn, k);
      check("t1_pre", preambleDone, (k >= 8) ? 1 : 0);
      check("t1_msg", messageDone, 0);
    end
    next(); settle();
    check("t1_msg_done", messageDone, 1);
    check("t1_pre_done", preambleDone, 1);
    check("t1_busy_done", busy, 0);
    check("t1_empty_done", fInValid, 0);
    check_log_seq("t1_reads", 0, 10);
    check_log_seq("t1_pops", 1, 10);

    // len=20 with backpressure: reads stop when credit is exhausted
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 20; getNext = 1'b0;
    settle();
    next(); start = 1'b0;
    settle();
    repeat (9) begin next(); settle(); end
    check("t2_reads_full", rd_log.size(), 4);
    check("t2_rd_stalled", mem_rd, 0);
    check("t2_head_valid", fInValid, 1);
    check("t2_head", fIn, 0);
    next(); getNext = 1'b1;
    settle();
    check("t2_rd_still_full", mem_rd, 0);
    next(); settle();
    check("t2_rd_resume", mem_rd, 1);
    check("t2_addr_resume", mem_addr, 4);
    run_until_done("t2_done_timeout", 100);
    check_log_seq("t2_reads", 0, 20);
    check_log_seq("t2_pops", 1, 20);

    // len=5 < PRE_LEN, getNext high while empty
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 5; getNext = 1'b1;
    settle();
    next(); start = 1'b0;
    settle();
    check("t3_empty_c1", fInValid, 0);
    next(); settle();
    check("t3_empty_c2", fInValid, 0);
    check("t3_pre_c2", preambleDone, 0);
    for (int k = 0; k < 5; k++) begin
      next(); settle();
      check("t3_byte", fIn, k);
      check("t3_pre", preambleDone, 0);
      check("t3_msg", messageDone, 0);
    end
    next(); settle();
    check("t3_pre_done", preambleDone, 1);
    check("t3_msg_done", messageDone, 1);
    check_log_seq("t3_pops", 1, 5);

    // Ignored start mid-message, then asynchronous reset
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 20; getNext = 1'b1;
    settle();
    next(); start = 1'b0;
    settle();
    next(); settle();
    for (int k = 0; k < 3; k++) begin
      next(); settle();
      check("t6_byte", fIn, k);
    end
    next(); getNext = 1'b0; start = 1'b1; msg_len = 2;
    settle();
    check("t6_busy_ign", busy, 1);
    check("t6_head_ign", fIn, 3);
    next(); start = 1'b0;
    settle();
    check("t6_busy_after", busy, 1);
    check("t6_head_after", fIn, 3);
    check("t6_msg_after", messageDone, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_async_outputs", out_vec(), 0);
    next();
    check("t6_reset_hold", out_vec(), 0);
    settle();
    rst = 1'b1;
    next(); settle();
    check("t6_idle_outputs", out_vec(), 0);

    // Fresh short message after reset
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 3; getNext = 1'b1;
    settle();
    next(); start = 1'b0;
    settle();
    run_until_done("t6_done_timeout", 50);
    check_log_seq("t6_reads", 0, 3);
    check_log_seq("t6_pops", 1, 3);

    // Restart from DONE
    rd_log.delete(); pop_log.delete();
    next(); start = 1'b1; msg_len = 4;
    settle();
    next(); start = 1'b0;
    settle();
    check("t7_msg_cleared", messageDone, 0);
    check("t7_busy", busy, 1);
    run_until_done("t7_done_timeout", 50);
    check_log_seq("t7_pops", 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
